// File: rtl/mem_lsu.sv
// Load/store unit with MEM/WB register, handshaked byte-lane RAM bus and bus timeout.
// Define MEM_LSU_ALIGN_CHECK_EN to trap misaligned half/word accesses instead of aligning them down.
module mem_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] sdata_i,
    input  logic [4:0]        wreg_addr_i,
    input  logic              wreg_we_i,
    input  logic [DATA_W-1:0] wreg_data_i,
    output logic              stall_o,
    output logic [4:0]        wb_addr_o,
    output logic              wb_we_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              exc_valid_o,
    output logic [1:0]        exc_code_o,
    output logic [ADDR_W-1:0] exc_badaddr_o
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);

    localparam logic [7:0] LB_OP  = 8'hE0;
    localparam logic [7:0] LH_OP  = 8'hE1;
    localparam logic [7:0] LW_OP  = 8'hE3;
    localparam logic [7:0] LBU_OP = 8'hE4;
    localparam logic [7:0] LHU_OP = 8'hE5;
    localparam logic [7:0] SB_OP  = 8'hE8;
    localparam logic [7:0] SH_OP  = 8'hE9;
    localparam logic [7:0] SW_OP  = 8'hEB;

    localparam logic [1:0] EXC_ADEL   = 2'b01;
    localparam logic [1:0] EXC_ADES   = 2'b10;
    localparam logic [1:0] EXC_BUSERR = 2'b11;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_t;
    typedef enum logic {IDLE, REQ} state_t;

    function automatic size_t op_size(input logic [7:0] op);
        case (op)
            LB_OP, LBU_OP, SB_OP: op_size = SZ_BYTE;
            LH_OP, LHU_OP, SH_OP: op_size = SZ_HALF;
            LW_OP, SW_OP:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_store(input logic [7:0] op);
        op_store = (op == SB_OP) || (op == SH_OP) || (op == SW_OP);
    endfunction

    state_t            state, state_next;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [4:0]        dest_q;
    logic [7:0]        wait_cnt;

    size_t             in_size, q_size;
    logic              in_mem, q_store, at_limit;
    logic              align_fault;
    logic [1:0]        align_code;
    logic [LANE_W-1:0] lane_off;
    logic [BYTES-1:0]  lane_mask;
    logic [DATA_W-1:0] store_data, load_shift, load_data;

    assign in_size  = op_size(op_i);
    assign in_mem   = valid_i && (in_size != SZ_NONE);
    assign q_size   = op_size(op_q);
    assign q_store  = op_store(op_q);
    assign at_limit = (wait_cnt == 8'(TIMEOUT));

`ifdef MEM_LSU_ALIGN_CHECK_EN
    logic in_misal;
    assign in_misal    = ((in_size == SZ_HALF) && addr_i[0]) ||
                         ((in_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
    assign align_fault = in_mem && in_misal;
    assign align_code  = op_store(op_i) ? EXC_ADES : EXC_ADEL;
`else
    assign align_fault = 1'b0;
    assign align_code  = EXC_ADEL;
`endif

    // Lane selection from the latched access; misaligned low bits are simply masked off.
    always_comb begin
        lane_off  = addr_q[LANE_W-1:0];
        lane_mask = BYTES'(15);
        case (q_size)
            SZ_BYTE: lane_mask = BYTES'(1);
            SZ_HALF: begin
                lane_off[0] = 1'b0;
                lane_mask   = BYTES'(3);
            end
            default: lane_off[1:0] = 2'b00;
        endcase
        case (q_size)
            SZ_BYTE: store_data = {BYTES{sdata_q[7:0]}};
            SZ_HALF: store_data = {(BYTES/2){sdata_q[15:0]}};
            default: store_data = {(BYTES/4){sdata_q[31:0]}};
        endcase
        load_shift = ram_rdata >> {lane_off, 3'b000};
        case (op_q)
            LB_OP:   load_data = DATA_W'($signed(load_shift[7:0]));
            LBU_OP:  load_data = DATA_W'(load_shift[7:0]);
            LH_OP:   load_data = DATA_W'($signed(load_shift[15:0]));
            LHU_OP:  load_data = DATA_W'(load_shift[15:0]);
            default: load_data = DATA_W'($signed(load_shift[31:0]));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus and exception outputs are combinational from state so reset drops them at once.
    always_comb begin
        state_next    = state;
        stall_o       = 1'b0;
        ram_ce        = 1'b0;
        ram_we        = 1'b0;
        ram_sel       = '0;
        ram_addr      = '0;
        ram_wdata     = '0;
        exc_valid_o   = 1'b0;
        exc_code_o    = 2'b00;
        exc_badaddr_o = '0;
        case (state)
            IDLE: begin
                if (align_fault) begin
                    exc_valid_o   = 1'b1;
                    exc_code_o    = align_code;
                    exc_badaddr_o = addr_i;
                end else if (in_mem) begin
                    stall_o    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!at_limit) begin
                    ram_ce    = 1'b1;
                    ram_we    = q_store;
                    ram_sel   = lane_mask << lane_off;
                    ram_addr  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    ram_wdata = q_store ? store_data : '0;
                end
                if (ram_ack) begin
                    state_next = IDLE;
                end else if (at_limit) begin
                    state_next    = IDLE;
                    exc_valid_o   = 1'b1;
                    exc_code_o    = EXC_BUSERR;
                    exc_badaddr_o = addr_q;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Access latch, wait counter and the MEM/WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            dest_q    <= '0;
            wait_cnt  <= '0;
            wb_addr_o <= '0;
            wb_we_o   <= 1'b0;
            wb_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_mem && !align_fault) begin
                        op_q     <= op_i;
                        addr_q   <= addr_i;
                        sdata_q  <= sdata_i;
                        dest_q   <= wreg_addr_i;
                        wait_cnt <= '0;
                        wb_we_o  <= 1'b0;
                    end else begin
                        wb_addr_o <= wreg_addr_i;
                        wb_data_o <= wreg_data_i;
                        wb_we_o   <= wreg_we_i && valid_i && !align_fault;
                    end
                end
                REQ: begin
                    if (ram_ack) begin
                        wb_we_o <= !q_store;
                        if (!q_store) begin
                            wb_addr_o <= dest_q;
                            wb_data_o <= load_data;
                        end
                    end else if (at_limit) begin
                        wb_we_o <= 1'b0;
                    end else begin
                        wb_we_o  <= 1'b0;
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: wb_we_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: the driver queues expected WB/bus/exception results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_lsu;

    localparam int TIMEOUT = 15;

    localparam logic [7:0] ALU_OP = 8'h21;
    localparam logic [7:0] LB_OP  = 8'hE0;
    localparam logic [7:0] LH_OP  = 8'hE1;
    localparam logic [7:0] LW_OP  = 8'hE3;
    localparam logic [7:0] LBU_OP = 8'hE4;
    localparam logic [7:0] LHU_OP = 8'hE5;
    localparam logic [7:0] SB_OP  = 8'hE8;
    localparam logic [7:0] SH_OP  = 8'hE9;
    localparam logic [7:0] SW_OP  = 8'hEB;

    logic        clk, rst, valid_i;
    logic [7:0]  op_i;
    logic [31:0] addr_i, sdata_i, wreg_data_i;
    logic [4:0]  wreg_addr_i;
    logic        wreg_we_i;
    logic        stall_o;
    logic [4:0]  wb_addr_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ack;
    logic        exc_valid_o;
    logic [1:0]  exc_code_o;
    logic [31:0] exc_badaddr_o;

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
        .sdata_i(sdata_i), .wreg_addr_i(wreg_addr_i), .wreg_we_i(wreg_we_i),
        .wreg_data_i(wreg_data_i), .stall_o(stall_o), .wb_addr_o(wb_addr_o),
        .wb_we_o(wb_we_o), .wb_data_o(wb_data_o), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .exc_valid_o(exc_valid_o),
        .exc_code_o(exc_code_o), .exc_badaddr_o(exc_badaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        we;
        logic [31:0] data;
        logic        check_data;
        int          stalls;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] badaddr;
    } exc_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    exc_exp_t exc_q[$];

    int   checks = 0;
    int   passes = 0;
    logic track = 1'b0;
    logic wb_pending = 1'b0;
    logic prev_ce = 1'b0;
    int   cur_stall = 0;
    int   done_stall = 0;

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic expectWb(input logic [4:0] a, input logic we, input logic [31:0] d,
                            input logic chk, input int stalls);
        wb_exp_t e;
        e.addr = a; e.we = we; e.data = d; e.check_data = chk; e.stalls = stalls;
        wb_q.push_back(e);
    endtask

    task automatic expectBus(input logic we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd);
        bus_exp_t e;
        e.we = we; e.sel = sel; e.addr = a; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic expectExc(input logic [1:0] code, input logic [31:0] a);
        exc_exp_t e;
        e.code = code; e.badaddr = a;
        exc_q.push_back(e);
    endtask

    // Called at posedge+1; holds the instruction like a stalled pipeline and returns at
    // posedge+1 of the cycle after it retires. waits < 0 means no bus access is expected.
    task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [4:0] dst, input logic we,
                                 input logic [31:0] wd, input int waits, input logic ack_last,
                                 input logic [31:0] rdata);
        valid_i = v; op_i = op; addr_i = a; sdata_i = sd;
        wreg_addr_i = dst; wreg_we_i = we; wreg_data_i = wd;
        @(posedge clk); #1;
        if (waits >= 0) begin
            repeat (waits) begin
                @(posedge clk); #1;
            end
            ram_ack = ack_last;
            ram_rdata = rdata;
            @(posedge clk); #1;
            ram_ack = 1'b0;
        end
    endtask

    // Monitor: compares bus cycles, exception pulses and the WB bundle after each retirement.
    always @(negedge clk) begin
        if (ram_ce) begin
            if (bus_q.size() == 0) begin
                checkOutput("bus_unexpected", 96'(ram_ce), 96'(0));
            end else begin
                checkOutput("bus", {ram_we, ram_sel, ram_addr, (ram_we ? ram_wdata : 32'h0)},
                            {bus_q[0].we, bus_q[0].sel, bus_q[0].addr, (bus_q[0].we ? bus_q[0].wdata : 32'h0)});
            end
        end else if (prev_ce && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
        end
        prev_ce = ram_ce;

        if (exc_valid_o) begin
            if (exc_q.size() == 0) begin
                checkOutput("exc_unexpected", 96'(exc_valid_o), 96'(0));
            end else begin
                checkOutput("exc", {exc_code_o, exc_badaddr_o}, {exc_q[0].code, exc_q[0].badaddr});
                void'(exc_q.pop_front());
            end
        end

        if (wb_pending) begin
            wb_pending = 1'b0;
            if (wb_q.size() == 0) begin
                checkOutput("wb_unexpected", 96'(1), 96'(0));
            end else begin
                checkOutput("wb_we", 96'(wb_we_o), 96'(wb_q[0].we));
                checkOutput("stall_cycles", 96'(done_stall), 96'(wb_q[0].stalls));
                if (wb_q[0].check_data)
                    checkOutput("wb_bundle", {wb_addr_o, wb_data_o}, {wb_q[0].addr, wb_q[0].data});
                void'(wb_q.pop_front());
            end
        end

        if (rst) begin
            cur_stall = 0;
        end else if (track) begin
            if (stall_o) begin
                cur_stall++;
            end else begin
                wb_pending = 1'b1;
                done_stall = cur_stall;
                cur_stall  = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; op_i = '0; addr_i = '0; sdata_i = '0;
        wreg_addr_i = '0; wreg_we_i = 1'b0; wreg_data_i = '0;
        ram_rdata = '0; ram_ack = 1'b0;

        #12;
        checkOutput("reset_wb", {wb_addr_o, wb_we_o, wb_data_o, stall_o}, 96'(0));
        checkOutput("reset_bus", {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata}, 96'(0));
        checkOutput("reset_exc", {exc_valid_o, exc_code_o, exc_badaddr_o}, 96'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        track = 1'b1;

        expectWb(5'd3, 1'b1, 32'h12345678, 1'b1, 0);
        applyStimulus(1'b1, ALU_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678, -1, 1'b0, 32'h0);

        expectWb(5'd4, 1'b0, 32'hAAAA5555, 1'b1, 0);
        applyStimulus(1'b0, ALU_OP, 32'h0, 32'h0, 5'd4, 1'b1, 32'hAAAA5555, -1, 1'b0, 32'h0);

        expectBus(1'b0, 4'b1111, 32'h10, 32'h0);
        expectWb(5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 4);
        applyStimulus(1'b1, LW_OP, 32'h10, 32'h0, 5'd5, 1'b1, 32'h0, 3, 1'b1, 32'hDEADBEEF);

        expectBus(1'b0, 4'b1000, 32'h10, 32'h0);
        expectWb(5'd6, 1'b1, 32'hFFFFFF80, 1'b1, 1);
        applyStimulus(1'b1, LB_OP, 32'h13, 32'h0, 5'd6, 1'b1, 32'h0, 0, 1'b1, 32'h80123456);

        expectBus(1'b0, 4'b1000, 32'h10, 32'h0);
        expectWb(5'd6, 1'b1, 32'h00000080, 1'b1, 1);
        applyStimulus(1'b1, LBU_OP, 32'h13, 32'h0, 5'd6, 1'b1, 32'h0, 0, 1'b1, 32'h80123456);

        expectBus(1'b0, 4'b1100, 32'h10, 32'h0);
        expectWb(5'd7, 1'b1, 32'hFFFF8001, 1'b1, 1);
        applyStimulus(1'b1, LH_OP, 32'h12, 32'h0, 5'd7, 1'b1, 32'h0, 0, 1'b1, 32'h80011234);

        expectBus(1'b0, 4'b1100, 32'h10, 32'h0);
        expectWb(5'd7, 1'b1, 32'h00009ABC, 1'b1, 1);
        applyStimulus(1'b1, LHU_OP, 32'h12, 32'h0, 5'd7, 1'b1, 32'h0, 0, 1'b1, 32'h9ABC0000);

        expectBus(1'b1, 4'b1100, 32'h10, 32'hABCDABCD);
        expectWb(5'd0, 1'b0, 32'h0, 1'b0, 2);
        applyStimulus(1'b1, SH_OP, 32'h12, 32'h0000ABCD, 5'd0, 1'b0, 32'h0, 1, 1'b1, 32'h0);

        expectBus(1'b1, 4'b0010, 32'h24, 32'h77777777);
        expectWb(5'd0, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, SB_OP, 32'h25, 32'h12345677, 5'd0, 1'b0, 32'h0, 2, 1'b1, 32'h0);

`ifdef MEM_LSU_ALIGN_CHECK_EN
        expectExc(2'b10, 32'h21);
        expectWb(5'd0, 1'b0, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, SW_OP, 32'h21, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, -1, 1'b0, 32'h0);

        expectExc(2'b01, 32'h31);
        expectWb(5'd8, 1'b0, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, LH_OP, 32'h31, 32'h0, 5'd8, 1'b1, 32'h0, -1, 1'b0, 32'h0);
`else
        expectBus(1'b1, 4'b1111, 32'h20, 32'hCAFEF00D);
        expectWb(5'd0, 1'b0, 32'h0, 1'b0, 1);
        applyStimulus(1'b1, SW_OP, 32'h21, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, 0, 1'b1, 32'h0);

        expectBus(1'b0, 4'b0011, 32'h30, 32'h0);
        expectWb(5'd8, 1'b1, 32'hFFFFF00F, 1'b1, 1);
        applyStimulus(1'b1, LH_OP, 32'h31, 32'h0, 5'd8, 1'b1, 32'h0, 0, 1'b1, 32'h1234F00F);
`endif

        expectBus(1'b0, 4'b1111, 32'h40, 32'h0);
        expectExc(2'b11, 32'h40);
        expectWb(5'd9, 1'b0, 32'h0, 1'b0, TIMEOUT + 1);
        applyStimulus(1'b1, LW_OP, 32'h40, 32'h0, 5'd9, 1'b1, 32'h0, TIMEOUT, 1'b0, 32'h0);

        expectBus(1'b0, 4'b1111, 32'h44, 32'h0);
        expectWb(5'd11, 1'b1, 32'h11223344, 1'b1, TIMEOUT + 1);
        applyStimulus(1'b1, LW_OP, 32'h44, 32'h0, 5'd11, 1'b1, 32'h0, TIMEOUT, 1'b1, 32'h11223344);

        ram_ack = 1'b1;
        expectWb(5'd10, 1'b1, 32'h00000001, 1'b1, 0);
        applyStimulus(1'b1, ALU_OP, 32'h10, 32'h0, 5'd10, 1'b1, 32'h00000001, -1, 1'b0, 32'h0);
        ram_ack = 1'b0;

        // Reset lands in the second wait cycle of an LW that never completes.
        valid_i = 1'b1; op_i = LW_OP; addr_i = 32'h50; wreg_addr_i = 5'd12; wreg_we_i = 1'b1;
        expectBus(1'b0, 4'b1111, 32'h50, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; valid_i = 1'b0; track = 1'b0;
        #1;
        checkOutput("midreset_bus", {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata}, 96'(0));
        checkOutput("midreset_wb", {wb_addr_o, wb_we_o, wb_data_o, stall_o, exc_valid_o}, 96'(0));
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        track = 1'b1;

        expectWb(5'd13, 1'b1, 32'h5A5A5A5A, 1'b1, 0);
        applyStimulus(1'b1, ALU_OP, 32'h0, 32'h0, 5'd13, 1'b1, 32'h5A5A5A5A, -1, 1'b0, 32'h0);

        expectWb(5'd0, 1'b0, 32'h0, 1'b1, 0);
        applyStimulus(1'b0, ALU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, -1, 1'b0, 32'h0);
        track = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("wb_queue_left", 96'(wb_q.size()), 96'(0));
        checkOutput("bus_queue_left", 96'(bus_q.size()), 96'(0));
        checkOutput("exc_queue_left", 96'(exc_q.size()), 96'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
